alu_result_stage: RTL and testbench

//  Registered output stage directly downstream of the 4-bit Brent-Kung ALU selector.

---
 rtl/alu_result_stage.sv | 157 +++++++++++++++
 tb/tb_alu_result_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Registered result/flag stage behind the 4-bit ALU selector with a 2-entry skid buffer.
// Optional pop/overflow statistics counters are enabled by defining ALU_RESULT_STATS_EN.
module alu_result_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carry,
    input  logic [1:0]       in_sel,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic [1:0]       out_sel
`ifdef ALU_RESULT_STATS_EN
    ,
    output logic [7:0]       op_count,
    output logic [7:0]       ovf_count
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             zero;
        logic             neg;
        logic             ovf;
        logic [1:0]       sel;
    } entry_t;

    state_e state_q, state_d;
    logic   in_ready_q;
    entry_t out_q, skid_q, in_entry;
    logic   accept, pop;
    logic   load_out_in, load_out_skid, load_skid;

    assign accept = in_valid && in_ready_q;
    assign pop    = out_valid && out_ready;

    // Flags are computed once at accept so the stored entry is self-describing.
    always_comb begin
        in_entry        = '0;
        in_entry.result = in_result;
        in_entry.sel    = in_sel;
        in_entry.zero   = ~|in_result;
        in_entry.neg    = in_result[WIDTH-1];
        unique case (in_sel)
            2'b10: begin
                in_entry.carry = in_carry;
                in_entry.ovf   = (in_a_msb == in_b_msb) && (in_result[WIDTH-1] != in_a_msb);
            end
            2'b11: begin
                in_entry.carry = in_carry;
                in_entry.ovf   = (in_a_msb != in_b_msb) && (in_result[WIDTH-1] != in_a_msb);
            end
            default: begin
                in_entry.carry = 1'b0;
                in_entry.ovf   = 1'b0;
            end
        endcase
    end

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (pop && !accept) begin
                    state_d = EMPTY;
                end else if (accept && pop) begin
                    load_out_in = 1'b1;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d       = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; both entries are reset
    // so a mid-transfer reset leaves nothing stale to present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
            if (load_out_in) begin
                out_q <= in_entry;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != EMPTY);
    assign out_result = out_q.result;
    assign out_carry  = out_q.carry;
    assign out_zero   = out_q.zero;
    assign out_neg    = out_q.neg;
    assign out_ovf    = out_q.ovf;
    assign out_sel    = out_q.sel;

`ifdef ALU_RESULT_STATS_EN
    logic [7:0] op_count_q, ovf_count_q;

    // op_count wraps naturally; ovf_count saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q  <= '0;
            ovf_count_q <= '0;
        end else if (pop) begin
            op_count_q <= op_count_q + 8'd1;
            if (out_q.ovf && (ovf_count_q != 8'hFF)) begin
                ovf_count_q <= ovf_count_q + 8'd1;
            end
        end
    end

    assign op_count  = op_count_q;
    assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flag vectors, back-pressure, simultaneous
// accept/pop, mid-stream reset and (with ALU_RESULT_STATS_EN) the statistics counters.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [3:0] in_result;
    logic       in_carry;
    logic [1:0] in_sel;
    logic       in_a_msb, in_b_msb;
    logic       out_valid, out_ready;
    logic [3:0] out_result;
    logic       out_carry, out_zero, out_neg, out_ovf;
    logic [1:0] out_sel;
`ifdef ALU_RESULT_STATS_EN
    logic [7:0] op_count, ovf_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_carry  (in_carry),
        .in_sel    (in_sel),
        .in_a_msb  (in_a_msb),
        .in_b_msb  (in_b_msb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_ovf   (out_ovf),
        .out_sel   (out_sel)
`ifdef ALU_RESULT_STATS_EN
        ,
        .op_count  (op_count),
        .ovf_count (ovf_count)
`endif
    );

    typedef struct {
        string      name;
        logic [1:0] sel;
        logic [3:0] result;
        logic       carry;
        logic       a_msb;
        logic       b_msb;
        logic       exp_carry;
        logic       exp_zero;
        logic       exp_neg;
        logic       exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [3:0] res,
                         input logic c, input logic a, input logic b);
        in_valid  = v;
        in_sel    = sel;
        in_result = res;
        in_carry  = c;
        in_a_msb  = a;
        in_b_msb  = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".in_ready"}, in_ready, 1);
        check({tag, ".out_fields"},
              {out_result, out_carry, out_zero, out_neg, out_ovf, out_sel}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"add_ovf",   2'b10, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{"sub_borrow",2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"sub_zero",  2'b11, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{"and_zero",  2'b01, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{"xor_neg",   2'b00, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{"sub_ovf",   2'b11, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{"add_plain", 2'b10, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{"add_negovf",2'b10, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{"sub_same",  2'b11, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{"add_mixed", 2'b10, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        drive(1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        do_reset();
        check_all_zero("reset");

        // Single-entry flag vectors: accept, check, then pop back to EMPTY.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].sel, vecs[i].result, vecs[i].carry, vecs[i].a_msb, vecs[i].b_msb);
            step();
            check({vecs[i].name, ".valid"}, out_valid, 1);
            check({vecs[i].name, ".result"}, out_result, vecs[i].result);
            check({vecs[i].name, ".sel"}, out_sel, vecs[i].sel);
            check({vecs[i].name, ".flags"}, {out_carry, out_zero, out_neg, out_ovf},
                  {vecs[i].exp_carry, vecs[i].exp_zero, vecs[i].exp_neg, vecs[i].exp_ovf});
            in_valid = 1'b0;
            step();
            check({vecs[i].name, ".drained"}, out_valid, 0);
        end
        check("empty_hold.result", out_result, 4'b1100);

        // Back-pressure: two entries fill the buffer, a third is ignored.
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 4'b0001, 1'b0, 1'b0, 1'b0);
        step();
        check("bp1.in_ready", in_ready, 1);
        check("bp1.result", out_result, 4'b0001);
        drive(1'b1, 2'b10, 4'b0010, 1'b0, 1'b0, 1'b0);
        step();
        check("bp2.in_ready", in_ready, 0);
        check("bp2.result", out_result, 4'b0001);
        drive(1'b1, 2'b10, 4'b0011, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_ignored.in_ready", in_ready, 0);
        check("bp_ignored.result", out_result, 4'b0001);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_pop1.valid", out_valid, 1);
        check("bp_pop1.result", out_result, 4'b0010);
        check("bp_pop1.in_ready", in_ready, 1);
        step();
        check("bp_pop2.valid", out_valid, 0);
        check("bp_pop2.hold", out_result, 4'b0010);

        // Simultaneous accept and pop while in ONE.
        drive(1'b1, 2'b00, 4'b0100, 1'b0, 1'b0, 1'b0);
        step();
        check("sim_first.result", out_result, 4'b0100);
        drive(1'b1, 2'b00, 4'b0101, 1'b0, 1'b0, 1'b0);
        step();
        check("sim.valid", out_valid, 1);
        check("sim.result", out_result, 4'b0101);
        check("sim.in_ready", in_ready, 1);
        in_valid = 1'b0;
        step();
        check("sim_drain.valid", out_valid, 0);

        // Reset with two entries buffered.
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 4'b1000, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'b11, 4'b0111, 1'b1, 1'b1, 1'b0);
        step();
        check("pre_rst.in_ready", in_ready, 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        check_all_zero("mid_reset");
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check_all_zero("post_reset");

`ifdef ALU_RESULT_STATS_EN
        check("stats_reset.op", op_count, 0);
        check("stats_reset.ovf", ovf_count, 0);
        for (int i = 0; i < 256; i++) begin
            if (i == 5 || i == 100 || i == 200)
                drive(1'b1, 2'b10, 4'b1000, 1'b0, 1'b0, 1'b0);
            else
                drive(1'b1, 2'b10, 4'b0001, 1'b0, 1'b0, 1'b0);
            step();
            in_valid = 1'b0;
            step();
            if (i == 9) begin
                check("stats_mid.op", op_count, 10);
                check("stats_mid.ovf", ovf_count, 1);
            end
        end
        check("stats.op_wrap", op_count, 0);
        check("stats.ovf", ovf_count, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
